// File: rtl/wfq_pkg.sv
// Shared widths and FSM encoding for the WFQ weight/divide front end and its
// integration with wfq_engine.
package wfq_pkg;

   localparam int unsigned CLASS_WIDTH  = 5;
   localparam int unsigned WEIGHT_WIDTH = 16;
   localparam int unsigned PKT_WIDTH    = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDiv   = 2'd1,
      StIssue = 2'd2,
      StWait  = 2'd3
   } state_e;

endpackage

// File: rtl/seq_restoring_div.sv
// Restoring divider, one quotient bit per cycle. quotient/remainder show the
// result of the step in progress, so they are final in the cycle done=1.
module seq_restoring_div
   import wfq_pkg::*;
#(
   parameter int unsigned DVD_WIDTH = wfq_pkg::PKT_WIDTH,
   parameter int unsigned DVS_WIDTH = wfq_pkg::WEIGHT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DVD_WIDTH-1:0] dividend,
   input  logic [DVS_WIDTH-1:0] divisor,
   output logic                 done,
   output logic [DVD_WIDTH-1:0] quotient,
   output logic [DVS_WIDTH-1:0] remainder
);

   localparam int unsigned CntWidth = $clog2(DVD_WIDTH + 1);

   logic [DVD_WIDTH-1:0] dvd_q, dvd_d;
   logic [DVS_WIDTH-1:0] dvs_q, dvs_d;
   logic [DVS_WIDTH-1:0] rem_q, rem_d;
   logic [DVD_WIDTH-1:0] quo_q, quo_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;

   logic [DVS_WIDTH:0]   trial;
   logic [DVS_WIDTH:0]   diff;
   logic                 ge;
   logic [DVS_WIDTH-1:0] rem_step;
   logic [DVD_WIDTH-1:0] quo_step;

   always_comb begin
      trial    = {rem_q, dvd_q[DVD_WIDTH-1]};
      ge       = trial >= {1'b0, dvs_q};
      diff     = trial - {1'b0, dvs_q};
      // Both branches fit in DVS_WIDTH bits because the result is below the divisor.
      rem_step = ge ? diff[DVS_WIDTH-1:0] : trial[DVS_WIDTH-1:0];
      quo_step = {quo_q[DVD_WIDTH-2:0], ge};

      dvd_d = dvd_q;
      dvs_d = dvs_q;
      rem_d = rem_q;
      quo_d = quo_q;
      cnt_d = cnt_q;
      if (start) begin
         dvd_d = dividend;
         dvs_d = divisor;
         rem_d = '0;
         quo_d = '0;
         cnt_d = CntWidth'(DVD_WIDTH);
      end else if (cnt_q != '0) begin
         dvd_d = {dvd_q[DVD_WIDTH-2:0], 1'b0};
         rem_d = rem_step;
         quo_d = quo_step;
         cnt_d = cnt_q - CntWidth'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
      end else begin
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
      end
   end

   assign done      = (cnt_q == CntWidth'(1));
   assign quotient  = quo_step;
   assign remainder = rem_step;

endmodule

// File: rtl/wfq_weight_div.sv
// Per-class weight table plus sequential length/weight divide, issuing one
// request at a time to the WFQ engine and waiting for its completion.
module wfq_weight_div #(
   parameter int unsigned CLASS_WIDTH  = wfq_pkg::CLASS_WIDTH,
   parameter int unsigned WEIGHT_WIDTH = wfq_pkg::WEIGHT_WIDTH,
   parameter int unsigned PKT_WIDTH    = wfq_pkg::PKT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CLASS_WIDTH-1:0]  in_class_id,
   input  logic [PKT_WIDTH-1:0]    in_pkt_len,
   input  logic                    cfg_wr_en,
   input  logic [CLASS_WIDTH-1:0]  cfg_class_id,
   input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
   output logic                    out_valid,
   output logic [CLASS_WIDTH-1:0]  out_class_id,
   output logic [PKT_WIDTH-1:0]    out_quotient,
   output logic [WEIGHT_WIDTH-1:0] out_remain,
   input  logic                    eng_done
);

   import wfq_pkg::*;

   localparam int unsigned NumClasses = 2 ** CLASS_WIDTH;

   logic [WEIGHT_WIDTH-1:0] weight_q [NumClasses];
   logic [WEIGHT_WIDTH-1:0] weight_d [NumClasses];
   logic [WEIGHT_WIDTH-1:0] in_weight;

   state_e                  state_q, state_d;
   logic [CLASS_WIDTH-1:0]  class_q, class_d;
   logic [CLASS_WIDTH-1:0]  out_class_q, out_class_d;
   logic [PKT_WIDTH-1:0]    out_quo_q, out_quo_d;
   logic [WEIGHT_WIDTH-1:0] out_rem_q, out_rem_d;

   logic                    div_start;
   logic                    div_done;
   logic [PKT_WIDTH-1:0]    div_quotient;
   logic [WEIGHT_WIDTH-1:0] div_remainder;

   // Reads see the table before any same-cycle write.
   assign in_weight = weight_q[in_class_id];

   always_comb begin
      weight_d = weight_q;
      if (cfg_wr_en) begin
         weight_d[cfg_class_id] = cfg_weight;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumClasses; i++) begin
            weight_q[i] <= WEIGHT_WIDTH'(1);
         end
      end else begin
         weight_q <= weight_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      class_d     = class_q;
      out_class_d = out_class_q;
      out_quo_d   = out_quo_q;
      out_rem_d   = out_rem_q;
      div_start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               class_d = in_class_id;
               if (in_weight == '0) begin
                  state_d     = StIssue;
                  out_class_d = in_class_id;
                  out_quo_d   = '1;
                  out_rem_d   = '0;
               end else begin
                  div_start = 1'b1;
                  state_d   = StDiv;
               end
            end
         end
         StDiv: begin
            if (div_done) begin
               state_d     = StIssue;
               out_class_d = class_q;
               out_quo_d   = div_quotient;
               out_rem_d   = div_remainder;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (eng_done) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         class_q     <= '0;
         out_class_q <= '0;
         out_quo_q   <= '0;
         out_rem_q   <= '0;
      end else begin
         state_q     <= state_d;
         class_q     <= class_d;
         out_class_q <= out_class_d;
         out_quo_q   <= out_quo_d;
         out_rem_q   <= out_rem_d;
      end
   end

   seq_restoring_div #(
      .DVD_WIDTH (PKT_WIDTH),
      .DVS_WIDTH (WEIGHT_WIDTH)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividend  (in_pkt_len),
      .divisor   (in_weight),
      .done      (div_done),
      .quotient  (div_quotient),
      .remainder (div_remainder)
   );

   assign in_ready     = (state_q == StIdle) && !rst;
   assign out_valid    = (state_q == StIssue);
   assign out_class_id = out_class_q;
   assign out_quotient = out_quo_q;
   assign out_remain   = out_rem_q;

endmodule

// File: tb/tb_wfq_weight_div.sv
// Directed bench for wfq_weight_div: expected requests go into a scoreboard
// queue, a monitor checks each out_valid pulse, and an engine model answers.
module tb_wfq_weight_div;

   localparam int unsigned CW = 5;
   localparam int unsigned WW = 16;
   localparam int unsigned PW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_class_id = '0;
   logic [PW-1:0] in_pkt_len = '0;
   logic          cfg_wr_en = 1'b0;
   logic [CW-1:0] cfg_class_id = '0;
   logic [WW-1:0] cfg_weight = '0;
   logic          out_valid;
   logic [CW-1:0] out_class_id;
   logic [PW-1:0] out_quotient;
   logic [WW-1:0] out_remain;
   logic          eng_done = 1'b0;

   wfq_weight_div dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_class_id  (in_class_id),
      .in_pkt_len   (in_pkt_len),
      .cfg_wr_en    (cfg_wr_en),
      .cfg_class_id (cfg_class_id),
      .cfg_weight   (cfg_weight),
      .out_valid    (out_valid),
      .out_class_id (out_class_id),
      .out_quotient (out_quotient),
      .out_remain   (out_remain),
      .eng_done     (eng_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [CW-1:0] cls;
      logic [PW-1:0] quo;
      logic [WW-1:0] rem;
      int            at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total_cnt = 0;
   int   pass_cnt = 0;
   int   last_done_cyc = -100;
   bit   outstanding = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every out_valid pulse must match the oldest expected request.
   always @(negedge clk) begin
      if (rst) begin
         outstanding = 1'b0;
      end else begin
         if (eng_done) outstanding = 1'b0;
         if (out_valid) begin
            check("single_outstanding", 32'(outstanding), 32'd0);
            outstanding = 1'b1;
            if (sb.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               check("out_class_id", 32'(out_class_id), 32'(mon_e.cls));
               check("out_quotient", 32'(out_quotient), 32'(mon_e.quo));
               check("out_remain", 32'(out_remain), 32'(mon_e.rem));
               check("out_valid_cycle", 32'(cyc), 32'(mon_e.at));
            end
         end
      end
   end

   // Engine model: completion three cycles after each request.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            repeat (3) @(posedge clk);
            #1 eng_done = 1'b1;
            last_done_cyc = cyc;
            @(posedge clk);
            #1 eng_done = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_accept(output int t);
      t = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_valid && in_ready) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         total_cnt++;
         $display("FAIL accept_timeout: got no accept, expected accept within 100 cycles");
      end
   endtask

   task automatic wait_idle();
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) check("ready_after_done", 32'(cyc), 32'(last_done_cyc + 1));
      else begin
         total_cnt++;
         $display("FAIL idle_timeout: got in_ready=0, expected 1 within 100 cycles");
      end
   endtask

   task automatic cfg(input logic [CW-1:0] cls, input logic [WW-1:0] w);
      @(posedge clk);
      #1 cfg_wr_en = 1'b1;
      cfg_class_id = cls;
      cfg_weight = w;
      @(posedge clk);
      #1 cfg_wr_en = 1'b0;
   endtask

   task automatic send(input logic [CW-1:0] cls, input logic [PW-1:0] len,
                       input logic [PW-1:0] q, input logic [WW-1:0] r, input int lat,
                       input bit do_cfg, input logic [WW-1:0] cfg_w);
      int t;
      @(posedge clk);
      #1 in_valid = 1'b1;
      in_class_id = cls;
      in_pkt_len = len;
      cfg_wr_en = do_cfg;
      cfg_class_id = cls;
      cfg_weight = cfg_w;
      wait_accept(t);
      if (t >= 0) sb.push_back('{cls, q, r, t + lat});
      @(posedge clk);
      #1 in_valid = 1'b0;
      cfg_wr_en = 1'b0;
   endtask

   initial begin
      int t;
      int t2;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_class_id", 32'(out_class_id), 32'd0);
      check("rst_out_quotient", 32'(out_quotient), 32'd0);
      check("rst_out_remain", 32'(out_remain), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(in_ready), 32'd1);

      send(5'd3, 16'hFFFF, 16'hFFFF, 16'd0, 17, 1'b0, 16'd0);
      wait_idle();
      cfg(5'd2, 16'd3);
      send(5'd2, 16'd1000, 16'd333, 16'd1, 17, 1'b0, 16'd0);
      wait_idle();
      cfg(5'd5, 16'd7);
      send(5'd5, 16'd5, 16'd0, 16'd5, 17, 1'b0, 16'd0);
      wait_idle();
      cfg(5'd6, 16'd0);
      send(5'd6, 16'd100, 16'hFFFF, 16'd0, 1, 1'b0, 16'd0);
      wait_idle();

      // Same-cycle write of weight[4] must not affect the packet being accepted.
      cfg(5'd4, 16'd4);
      send(5'd4, 16'd40, 16'd10, 16'd0, 17, 1'b1, 16'd10);
      wait_idle();
      send(5'd4, 16'd40, 16'd4, 16'd0, 17, 1'b0, 16'd0);
      wait_idle();

      // Two descriptors with in_valid held high; stray eng_done during DIV.
      @(posedge clk);
      #1 in_valid = 1'b1;
      in_class_id = 5'd2;
      in_pkt_len = 16'd10;
      wait_accept(t);
      if (t >= 0) sb.push_back('{5'd2, 16'd3, 16'd1, t + 17});
      @(posedge clk);
      #1 in_class_id = 5'd5;
      in_pkt_len = 16'd50;
      repeat (3) @(posedge clk);
      #1 eng_done = 1'b1;
      @(posedge clk);
      #1 eng_done = 1'b0;
      wait_accept(t2);
      if (t2 >= 0) begin
         check("b2b_accept_after_done", 32'(t2), 32'(last_done_cyc + 1));
         sb.push_back('{5'd5, 16'd7, 16'd1, t2 + 17});
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_idle();

      // Reset in the middle of a division.
      @(posedge clk);
      #1 in_valid = 1'b1;
      in_class_id = 5'd3;
      in_pkt_len = 16'd77;
      wait_accept(t);
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_class_id", 32'(out_class_id), 32'd0);
      check("midrst_out_quotient", 32'(out_quotient), 32'd0);
      check("midrst_out_remain", 32'(out_remain), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (25) @(negedge clk);
      check("midrst_idle", 32'(in_ready), 32'd1);

      // Weights are back to 1 after reset.
      send(5'd2, 16'd1000, 16'd1000, 16'd0, 17, 1'b0, 16'd0);
      wait_idle();
      send(5'd6, 16'd100, 16'd100, 16'd0, 17, 1'b0, 16'd0);
      wait_idle();

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
